// File: rtl/systolic_array_controller.sv
// Sequencer for an N x N systolic matmul: clears the array, issues skewed per-lane
// operand indices with a bubble after each slot, drains, then strobes CAPTURE/DONE.
module systolic_array_controller #(
  parameter int N            = 4,
  parameter int KW           = $clog2(N),
  parameter int ISSUE_GAP    = 2,
  parameter int CLR_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 2*N+4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic          OPND_READY,
  output logic          BUSY,
  output logic          ARRAY_CLR,
  output logic          ISSUE,
  output logic [N-1:0]  LANE_VALID,
  output logic [N*KW-1:0] LANE_K,
  output logic          CAPTURE,
  output logic          DONE
);

  // state | meaning
  // IDLE  | waiting for START
  // CLEAR | ARRAY_CLR held for CLR_CYCLES
  // FEED  | issuing slots 0..2N-2, one bubble-separated issue per slot
  // DRAIN | waiting DRAIN_CYCLES for the pipeline to empty
  // FIN   | one-cycle CAPTURE/DONE
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int SW    = $clog2(2*N);
  localparam int DW    = SW + 1;
  localparam int GW    = $clog2(ISSUE_GAP + 1);
  localparam int CMAX  = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(2*N-2);

  logic [2:0]      r_state, w_nxt_state;
  logic [SW-1:0]   r_s, w_nxt_s;
  logic [GW-1:0]   r_g, w_nxt_g;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic            r_busy, r_clr, r_issue, r_fin;
  logic [N-1:0]    r_lane_valid, w_lane_valid;
  logic [N*KW-1:0] r_lane_k, w_lane_k;
  logic            w_issue;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_s     = r_s;
    w_nxt_g     = r_g;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_nxt_state = S_CLEAR;
          w_nxt_cnt   = CW'(CLR_CYCLES - 1);
        end
      end
      S_CLEAR: begin
        if (ABORT) begin
          w_nxt_state = S_IDLE;
        end else if (r_cnt == '0) begin
          w_nxt_state = S_FEED;
          w_nxt_s     = '0;
          w_nxt_g     = '0;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      S_FEED: begin
        if (ABORT) begin
          w_nxt_state = S_IDLE;
        end else if (r_g == '0) begin
          // r_issue says whether this g==0 cycle actually issued; if not, it is a stall
          if (r_issue) w_nxt_g = GW'(1);
        end else if (r_g == GW'(ISSUE_GAP - 1)) begin
          w_nxt_g = '0;
          if (r_s == LAST_SLOT) begin
            w_nxt_state = S_DRAIN;
            w_nxt_cnt   = CW'(DRAIN_CYCLES - 1);
          end else begin
            w_nxt_s = r_s + 1'b1;
          end
        end else begin
          w_nxt_g = r_g + 1'b1;
        end
      end
      S_DRAIN: begin
        if (ABORT) begin
          w_nxt_state = S_IDLE;
        end else if (r_cnt == '0) begin
          w_nxt_state = S_FIN;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      S_FIN:   w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the issue decision samples OPND_READY at the edge
  assign w_issue = (w_nxt_state == S_FEED) && (w_nxt_g == '0) && OPND_READY;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] w_d;
    assign w_d = {1'b0, w_nxt_s} - DW'(gi);
    assign w_lane_valid[gi] = w_issue && ({1'b0, w_nxt_s} >= DW'(gi)) && (w_d < DW'(N));
    assign w_lane_k[gi*KW +: KW] = w_lane_valid[gi] ? w_d[KW-1:0] : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_s          <= '0;
      r_g          <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_clr        <= 1'b0;
      r_issue      <= 1'b0;
      r_fin        <= 1'b0;
      r_lane_valid <= '0;
      r_lane_k     <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_s          <= w_nxt_s;
      r_g          <= w_nxt_g;
      r_cnt        <= w_nxt_cnt;
      r_busy       <= (w_nxt_state != S_IDLE);
      r_clr        <= (w_nxt_state == S_CLEAR);
      r_issue      <= w_issue;
      r_fin        <= (w_nxt_state == S_FIN);
      r_lane_valid <= w_lane_valid;
      r_lane_k     <= w_lane_k;
    end
  end

  assign BUSY       = r_busy;
  assign ARRAY_CLR  = r_clr;
  assign ISSUE      = r_issue;
  assign LANE_VALID = r_lane_valid;
  assign LANE_K     = r_lane_k;
  assign CAPTURE    = r_fin;
  assign DONE       = r_fin;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Directed bench for systolic_array_controller (N=4): per-cycle output masks over a job
// window are compared against hand-derived cycle numbers and lane skew values.
module tb_systolic_array_controller;
  localparam int N  = 4;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, opnd_ready;
  logic          busy, array_clr, issue, capture, done;
  logic [N-1:0]  lane_valid;
  logic [N*KW-1:0] lane_k;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_busy, m_clr, m_issue, m_done, m_cap;
  logic [N-1:0]    snap_v [64];
  logic [N*KW-1:0] snap_k [64];

  systolic_array_controller #(.N(N)) dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .OPND_READY(opnd_ready),
    .BUSY(busy), .ARRAY_CLR(array_clr), .ISSUE(issue), .LANE_VALID(lane_valid),
    .LANE_K(lane_k), .CAPTURE(capture), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int lo, input int hi, input int step);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k <= hi; k += step) m[k] = 1'b1;
    return m;
  endfunction

  // Cycle k is the cycle following the k-th edge after the one that samples START
  task automatic run_job(input int ncyc, input int sf, input int sl, input int ab,
                         input int xs1, input int xs2);
    m_busy = '0; m_clr = '0; m_issue = '0; m_done = '0; m_cap = '0;
    start = 1'b1; abort = 1'b0; opnd_ready = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      m_busy[k] = busy; m_clr[k] = array_clr; m_issue[k] = issue;
      m_done[k] = done; m_cap[k] = capture;
      snap_v[k] = lane_valid; snap_k[k] = lane_k;
      start      = (k == xs1) || (k == xs2);
      abort      = (k == ab);
      opnd_ready = !(k >= sf && k < sf + sl);
    end
    start = 1'b0; abort = 1'b0; opnd_ready = 1'b1;
  endtask

  task automatic check_nominal(input string pfx);
    check({pfx, "_clr"},   m_clr,   mk(1, 2, 1));
    check({pfx, "_issue"}, m_issue, mk(3, 15, 2));
    check({pfx, "_busy"},  m_busy,  mk(1, 29, 1));
    check({pfx, "_done"},  m_done,  mk(29, 29, 1));
    check({pfx, "_cap"},   m_cap,   mk(29, 29, 1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; opnd_ready = 1'b1;
    #1;
    check("reset_outputs", {busy, array_clr, issue, lane_valid, lane_k, capture, done}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal job and lane skew
    run_job(31, 99, 0, 99, 99, 99);
    check_nominal("nom");
    check("slot0_valid", snap_v[3],  4'b0001);
    check("slot0_k",     snap_k[3],  8'h00);
    check("bubble_valid", snap_v[4], 4'b0000);
    check("slot3_valid", snap_v[9],  4'b1111);
    check("slot3_k",     snap_k[9],  8'h1B);
    check("slot5_valid", snap_v[13], 4'b1100);
    check("slot5_k",     snap_k[13], 8'hB0);
    check("slot6_valid", snap_v[15], 4'b1000);
    check("slot6_k",     snap_k[15], 8'hC0);

    // Five-cycle stall at slot 2
    run_job(36, 6, 5, 99, 99, 99);
    check("stall_issue", m_issue, mk(3, 5, 2) | mk(12, 20, 2));
    check("stall_done",  m_done,  mk(34, 34, 1));
    check("stall_busy",  m_busy,  mk(1, 34, 1));
    check("stall_slot2_valid", snap_v[12], 4'b0111);
    check("stall_slot2_k",     snap_k[12], 8'h06);
    check("stall_hold_valid",  snap_v[9],  4'b0000);

    // Abort during slot 4, then a fresh nominal job
    run_job(14, 99, 0, 11, 99, 99);
    check("abort_busy",  m_busy,  mk(1, 11, 1));
    check("abort_issue", m_issue, mk(3, 11, 2));
    check("abort_done",  m_done,  '0);
    run_job(31, 99, 0, 99, 99, 99);
    check_nominal("post_abort");

    // Async reset mid-DRAIN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {busy, array_clr, issue, lane_valid, lane_k, capture, done}, '0);
    @(negedge clk);
    rst = 1'b0;
    m_busy = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m_busy[k] = busy | array_clr | issue | done;
    end
    check("idle_after_reset", m_busy, '0);

    // START ignored during FEED and FIN
    run_job(34, 99, 0, 99, 6, 29);
    check_nominal("ign_start");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
